// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, FSM states, timeout default
// and lane helpers. Optional build macro: MEM_MISALIGN_TRAP_EN (see memory_access.sv).
package memory_access_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int TIMEOUT_CYC_DEF = 255;
    localparam int CNT_W           = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // sz is funct3[1:0]: 0 byte, 1 half, 2 word. Sub-size address bits are truncated.
    function automatic logic [1:0] lane_off(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   return a;
            2'b01:   return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        return ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
interface memory_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/memory_access_load_align.sv
// Combinational load extraction: picks the byte/half lane from the read word and
// sign- or zero-extends it according to the load funct3.
module load_align
    import memory_access_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_data = {24'h0, w_byte};
            F3_HU:   o_data = {16'h0, w_half};
            default: o_data = i_rdata;
        endcase
    end
endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: passes non-memory results through in one cycle and runs
// loads/stores over the dmem bus with a timeout. MEM_MISALIGN_TRAP_EN traps misaligned accesses.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_funct3,
    input  logic        w_reg_in,
    input  logic [4:0]  dst_addr_in,
    input  logic [31:0] notbranch_in,
    input  logic [31:0] branch_in,
    input  logic [3:0]  info_branch_in,
    output logic        stall,
    output logic        out_valid,
    output logic        w_reg,
    output logic [31:0] rd_data,
    output logic [4:0]  dst_addr,
    output logic [31:0] notbranch,
    output logic [31:0] branch,
    output logic [3:0]  info_branch,
    output logic        bus_err,
    memory_access_if.master dmem
);
    state_t             r_state;
    state_t             w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_stall, r_out_valid, r_w_reg, r_bus_err;
    logic [31:0]        r_rd_data, r_nb, r_br;
    logic [4:0]         r_dst;
    logic [3:0]         r_info;
    logic               r_req, r_we;
    logic [31:0]        r_addr, r_wdata;
    logic [3:0]         r_be;
    logic [2:0]         r_f3;
    logic [1:0]         r_off;
    logic               r_is_load, r_wr_en;

    logic               w_accept, w_start, w_trap, w_done, w_tmo, w_mis, w_is_mem;
    logic [1:0]         w_off;
    logic [31:0]        w_load;

    assign w_is_mem = mem_read | mem_write;
    assign w_off    = lane_off(mem_funct3[1:0], alu_result[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_mis = misaligned(mem_funct3[1:0], alu_result[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    load_align u_load_align (
        .i_funct3 (r_f3),
        .i_off    (r_off),
        .i_rdata  (dmem.dmem_rdata),
        .o_data   (w_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    // Ack takes priority over timeout when both land on the last permitted BUSY cycle.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_start    = 1'b0;
        w_trap     = 1'b0;
        w_done     = 1'b0;
        w_tmo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (w_is_mem && w_mis) begin
                        w_trap = 1'b1;
                    end else if (w_is_mem) begin
                        w_start    = 1'b1;
                        w_state_nx = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (dmem.dmem_ack) begin
                    w_done     = 1'b1;
                    w_state_nx = ST_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_tmo      = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_stall     <= 1'b0;
            r_out_valid <= 1'b0;
            r_w_reg     <= 1'b0;
            r_bus_err   <= 1'b0;
            r_rd_data   <= 32'h0;
            r_dst       <= 5'h0;
            r_nb        <= 32'h0;
            r_br        <= 32'h0;
            r_info      <= 4'h0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_be        <= 4'h0;
            r_wdata     <= 32'h0;
            r_f3        <= 3'h0;
            r_off       <= 2'h0;
            r_is_load   <= 1'b0;
            r_wr_en     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_bus_err   <= 1'b0;
            r_w_reg     <= 1'b0;
            if (w_accept) begin
                r_dst     <= dst_addr_in;
                r_nb      <= notbranch_in;
                r_br      <= branch_in;
                r_info    <= info_branch_in;
                r_f3      <= mem_funct3;
                r_off     <= w_off;
                r_is_load <= ~mem_write;
                r_wr_en   <= w_reg_in;
            end
            if (w_accept && !w_is_mem) begin
                r_out_valid <= 1'b1;
                r_w_reg     <= w_reg_in;
                r_rd_data   <= alu_result;
            end
            if (w_trap) begin
                r_out_valid <= 1'b1;
                r_bus_err   <= 1'b1;
            end
            if (w_start) begin
                r_req   <= 1'b1;
                r_we    <= mem_write;
                r_addr  <= {alu_result[31:2], 2'b00};
                r_be    <= byte_en(mem_funct3[1:0], w_off);
                r_wdata <= store_lanes(mem_funct3[1:0], store_data);
                r_stall <= 1'b1;
                r_cnt   <= '0;
            end
            if (r_state == ST_BUSY && !w_done && !w_tmo) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_done) begin
                r_req       <= 1'b0;
                r_stall     <= 1'b0;
                r_out_valid <= 1'b1;
                r_w_reg     <= r_is_load & r_wr_en;
                if (r_is_load) r_rd_data <= w_load;
            end
            if (w_tmo) begin
                r_req       <= 1'b0;
                r_stall     <= 1'b0;
                r_out_valid <= 1'b1;
                r_bus_err   <= 1'b1;
            end
        end
    end

    assign stall           = r_stall;
    assign out_valid       = r_out_valid;
    assign w_reg           = r_w_reg;
    assign rd_data         = r_rd_data;
    assign dst_addr        = r_dst;
    assign notbranch       = r_nb;
    assign branch          = r_br;
    assign info_branch     = r_info;
    assign bus_err         = r_bus_err;
    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;
endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed cases plus randomized ops checked against an
// arithmetic reference model of lane selection, byte enables and load extension.
module tb_memory_access;
    import memory_access_pkg::*;

    localparam int TMO = 4;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] alu_result, store_data;
    logic        mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic        w_reg_in;
    logic [4:0]  dst_addr_in;
    logic [31:0] notbranch_in, branch_in;
    logic [3:0]  info_branch_in;
    logic        stall, out_valid, w_reg, bus_err;
    logic [31:0] rd_data, notbranch, branch;
    logic [4:0]  dst_addr;
    logic [3:0]  info_branch;

    memory_access_if dmem();

    memory_access #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
        .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_funct3(mem_funct3), .w_reg_in(w_reg_in), .dst_addr_in(dst_addr_in),
        .notbranch_in(notbranch_in), .branch_in(branch_in), .info_branch_in(info_branch_in),
        .stall(stall), .out_valid(out_valid), .w_reg(w_reg), .rd_data(rd_data),
        .dst_addr(dst_addr), .notbranch(notbranch), .branch(branch),
        .info_branch(info_branch), .bus_err(bus_err), .dmem(dmem)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size in bytes, aligned lane offset, masks, lanes, extension.
    function automatic int m_sz(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        int s = m_sz(f3);
        return ((int'(a[1:0])) / s) * s;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int v = ((1 << m_sz(f3)) - 1) << m_off(f3, a);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        int s = m_sz(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % s) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint v;
        int s = m_sz(f3);
        v = (longint'(rd) >> (8 * m_off(f3, a))) & ((64'sd1 <<< (8 * s)) - 1);
        if (!f3[2] && s < 4 && (((v >> (8 * s - 1)) & 1) == 1)) v = v - (64'sd1 <<< (8 * s));
        return v[31:0];
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % m_sz(f3)) != 0;
    endfunction

    // kind: 0 non-memory, 1 load, 2 store; dly: cycles of ack withheld, or -1 for no ack.
    task automatic do_op(input string tag, input int kind, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdv,
                         input logic wr, input int dly);
        logic [4:0]  dst;
        logic [31:0] nb, br;
        logic [3:0]  info;
        int          stalls, nwait;
        bit          trap, acked;
        dst = 5'($urandom); nb = $urandom; br = $urandom; info = 4'($urandom);
        in_valid = 1'b1; alu_result = a; store_data = sd; mem_funct3 = f3; w_reg_in = wr;
        mem_read = (kind == 1); mem_write = (kind == 2);
        dst_addr_in = dst; notbranch_in = nb; branch_in = br; info_branch_in = info;
        step();
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        trap = (kind != 0) && TRAP && m_mis(f3, a);
        if (kind == 0 || trap) begin
            chk({tag, ".out_valid"}, out_valid, 1'b1);
            chk({tag, ".no_req"}, dmem.dmem_req, 1'b0);
            chk({tag, ".stall"}, stall, 1'b0);
            chk({tag, ".bus_err"}, bus_err, trap);
            chk({tag, ".w_reg"}, w_reg, (kind == 0) ? wr : 1'b0);
            if (kind == 0) chk({tag, ".rd_data"}, rd_data, a);
        end else begin
            chk({tag, ".req"}, dmem.dmem_req, 1'b1);
            chk({tag, ".we"}, dmem.dmem_we, kind == 2);
            chk({tag, ".addr"}, dmem.dmem_addr, {a[31:2], 2'b00});
            chk({tag, ".be"}, dmem.dmem_be, m_be(f3, a));
            if (kind == 2) chk({tag, ".wdata"}, dmem.dmem_wdata, m_wdata(f3, sd));
            acked  = (dly >= 0);
            nwait  = acked ? dly : TMO;
            stalls = 0;
            for (int i = 0; i < nwait; i++) begin
                chk({tag, ".req_hold"}, dmem.dmem_req, 1'b1);
                stalls += int'(stall);
                dmem.dmem_rdata = $urandom;
                step();
            end
            if (acked) begin
                dmem.dmem_ack = 1'b1; dmem.dmem_rdata = rdv;
                stalls += int'(stall);
                step();
                dmem.dmem_ack = 1'b0; dmem.dmem_rdata = $urandom;
            end
            chk({tag, ".stall_cycles"}, stalls, acked ? dly + 1 : TMO);
            chk({tag, ".done_valid"}, out_valid, 1'b1);
            chk({tag, ".req_drop"}, dmem.dmem_req, 1'b0);
            chk({tag, ".stall_drop"}, stall, 1'b0);
            chk({tag, ".bus_err"}, bus_err, !acked);
            chk({tag, ".w_reg"}, w_reg, (kind == 1 && acked) ? wr : 1'b0);
            if (kind == 1 && acked) chk({tag, ".rd_data"}, rd_data, m_load(f3, a, rdv));
        end
        chk({tag, ".dst"}, dst_addr, dst);
        chk({tag, ".nb"}, notbranch, nb);
        chk({tag, ".br"}, branch, br);
        chk({tag, ".info"}, info_branch, info);
        step();
        chk({tag, ".pulse_end"}, out_valid, 1'b0);
        chk({tag, ".err_end"}, bus_err, 1'b0);
        chk({tag, ".wreg_end"}, w_reg, 1'b0);
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        ld_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        st_f3 = '{F3_B, F3_H, F3_W};
        rst = 1'b1; in_valid = 1'b0; alu_result = 0; store_data = 0; mem_read = 0;
        mem_write = 0; mem_funct3 = 0; w_reg_in = 0; dst_addr_in = 0; notbranch_in = 0;
        branch_in = 0; info_branch_in = 0; dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 0;
        step(); step();
        chk("rst.out_valid", out_valid, 0);
        chk("rst.stall", stall, 0);
        chk("rst.req", dmem.dmem_req, 0);
        chk("rst.rd_data", rd_data, 0);
        chk("rst.notbranch", notbranch, 0);
        chk("rst.branch", branch, 0);
        chk("rst.bus_err", bus_err, 0);
        chk("rst.w_reg", w_reg, 0);
        rst = 1'b0;
        step();

        do_op("nonmem", 0, F3_B, 32'h1234, 0, 0, 1'b1, 0);
        do_op("lb", 1, F3_B, 32'h103, 0, 32'h80FF_0000, 1'b1, 3);
        do_op("sh", 2, F3_H, 32'h202, 32'hABCD, 0, 1'b1, 1);
        do_op("timeout", 1, F3_W, 32'h300, 0, 0, 1'b1, -1);
        do_op("lw_mis", 1, F3_W, 32'h101, 0, 32'hCAFE_F00D, 1'b1, 0);

        // Ack while idle must be ignored.
        dmem.dmem_ack = 1'b1;
        step();
        dmem.dmem_ack = 1'b0;
        chk("idle_ack.out_valid", out_valid, 0);
        chk("idle_ack.req", dmem.dmem_req, 0);
        chk("idle_ack.stall", stall, 0);

        // Asynchronous reset in the middle of a request.
        in_valid = 1'b1; mem_read = 1'b1; mem_funct3 = F3_W; alu_result = 32'h400;
        step();
        in_valid = 1'b0; mem_read = 1'b0;
        chk("rstbusy.req", dmem.dmem_req, 1);
        step();
        #2 rst = 1'b1;
        #1;
        chk("rstbusy.req_async", dmem.dmem_req, 0);
        chk("rstbusy.stall_async", stall, 0);
        rst = 1'b0;
        step();
        do_op("lw_after_rst", 1, F3_W, 32'h404, 0, 32'h1357_9BDF, 1'b1, 2);

        // New instruction held on the inputs during a stall is taken only once idle.
        in_valid = 1'b1; mem_read = 1'b1; mem_funct3 = F3_BU; alu_result = 32'h501; w_reg_in = 1'b1;
        step();
        mem_read = 1'b0; alu_result = 32'h5555;
        chk("hold.stall", stall, 1);
        step();
        chk("hold.ignored", out_valid, 0);
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h0000_A500;
        step();
        dmem.dmem_ack = 1'b0;
        chk("hold.load_valid", out_valid, 1);
        chk("hold.load_data", rd_data, m_load(F3_BU, 32'h501, 32'h0000_A500));
        step();
        in_valid = 1'b0;
        chk("hold.next_valid", out_valid, 1);
        chk("hold.next_data", rd_data, 32'h5555);
        step();

        for (int n = 0; n < 60; n++) begin
            int kind, dly;
            logic [2:0] f3;
            kind = int'($urandom_range(0, 2));
            f3   = (kind == 2) ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
            dly  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 3));
            do_op("rand", kind, f3, $urandom, $urandom, $urandom, 1'($urandom), dly);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum cycles a data-memory request waits for dmem_ack before being aborted (legal range 1..1023).
REQ-002 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute-stage result valid.
- alu_result  in  32  effective address, or writeback value for non-memory ops.
- store_data  in  32  rs2 value for stores.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_funct3  in  3  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU (loads); 0 SB, 1 SH, 2 SW (stores).
- w_reg_in  in  1  register writeback enable.
- dst_addr_in  in  5  destination register.
- notbranch_in  in  32  sequential PC.
- branch_in  in  32  branch target.
- info_branch_in  in  4  branch info.
- stall  out  1  upstream hold.
- out_valid  out  1  writeback inputs valid.
- w_reg  out  1  writeback enable.
- rd_data  out  32  writeback data.
- dst_addr  out  5  destination register.
- notbranch  out  32  sequential PC.
- branch  out  32  branch target.
- info_branch  out  4  branch info.
- dmem_req  out  1  request.
- dmem_we  out  1  write.
- dmem_addr  out  32  word-aligned address.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_ack  in  1  completion.
- dmem_rdata  in  32  read word.
- bus_err  out  1  one-cycle pulse on timeout or misalign.

Function
REQ-003 SHALL implement FSM IDLE, BUSY, with all outputs registered.
REQ-004 In IDLE with in_valid and neither mem_read nor mem_write, SHALL latch pass-through fields and assert out_valid the next cycle (1-cycle latency), with rd_data = alu_result.
REQ-005 In IDLE with in_valid and (mem_read or mem_write), SHALL next cycle assert dmem_req, drive dmem_addr = {alu_result[31:2],2'b00}, drive be/wdata, assert stall, and enter BUSY.
REQ-006 dmem_be SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; all-zero for loads is forbidden (loads drive the same masks).
REQ-007 Store data SHALL be replicated across lanes: SB {4{b}}, SH {2{h}}, SW word.
REQ-008 In BUSY, request signals SHALL stay stable until the cycle dmem_ack=1; the next cycle SHALL deassert dmem_req and stall, assert out_valid, and return to IDLE.
REQ-009 Loads SHALL select the byte/half by addr[1:0] and sign-extend (LB, LH) or zero-extend (LBU, LHU); stores SHALL force w_reg=0.
REQ-010 dmem_ack in IDLE SHALL be ignored.
REQ-011 A wait counter SHALL count BUSY cycles; on reaching TIMEOUT_CYC without ack, SHALL drop dmem_req, pulse bus_err, emit out_valid with w_reg=0, and return to IDLE.
REQ-012 out_valid SHALL be a one-cycle pulse per accepted instruction; without in_valid, out_valid=0 and w_reg=0.
REQ-013 in_valid while stall=1 SHALL be ignored; upstream holds its values.

Reset
REQ-014 rst SHALL force IDLE, counter 0, and all outputs 0 (next_pc-related fields 32'h0) immediately, including mid-BUSY; a pending request is abandoned with dmem_req=0.

Configuration
REQ-015 With MEM_MISALIGN_TRAP_EN defined, an LH/LHU/SH with addr[0]=1 or an LW/SW with addr[1:0]!=0 SHALL issue no request, pulse bus_err, and emit out_valid with w_reg=0 after 1 cycle; without it, low address bits beyond the access size SHALL be truncated (half uses addr[1], word ignores addr[1:0]).

Structure
REQ-016 Funct3 encodings, FSM state encoding, and the TIMEOUT_CYC default SHALL live in the shared package/header.
REQ-017 Load extraction/extension SHALL be a sub-module load_align (combinational).

Verification
REQ-018 Non-memory op: alu_result=32'h1234, w_reg_in=1 -> next cycle out_valid=1, rd_data=32'h1234, no dmem_req.
REQ-019 LB addr 32'h103, dmem_rdata=32'h80FF_0000, ack after 3 cycles -> dmem_addr=32'h100, be=4'b1000, rd_data=32'hFFFF_FF80, stall held for 4 cycles.
REQ-020 SH addr 32'h202, store_data=32'hABCD -> be=4'b1100, wdata=32'hABCD_ABCD, w_reg=0.
REQ-021 No ack with TIMEOUT_CYC=4 -> dmem_req dropped after 4 BUSY cycles, bus_err pulse, out_valid with w_reg=0.
REQ-022 rst asserted mid-BUSY -> dmem_req=0, stall=0 asynchronously; a subsequent LW completes normally.
REQ-023 With MEM_MISALIGN_TRAP_EN, LW addr 32'h101 -> no dmem_req, bus_err pulse; without it -> request at 32'h100.
